rename_recovery_ctrl: RTL and testbench

//  Sequences rename-state recovery after a pipeline flush (mispredict/exception).

---
 rtl/rename_recovery_ctrl.sv | 156 +++++++++++++++
 tb/tb_rename_recovery_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rename_recovery_ctrl.sv
// rename_recovery_ctrl
//   Rebuilds rename state after a pipeline flush. The committed map (RRAT)
//   is copied into the front-end map (FRAT) one entry per cycle, then every
//   physical tag that the RRAT does not hold is returned to the free list in
//   ascending order. Rename and retirement are held for the whole walk.
//   All state updates happen on the falling edge of CLK.
//
// Ports
//   CLK            clock (falling-edge active)
//   RESET          asynchronous active-low reset
//   flush_req      one-cycle flush request; restarts recovery from any state
//   rrat_map       committed map, one TAG_W tag per architectural register
//   frat_wr_en     FRAT write strobe (COPY)
//   frat_wr_arch   FRAT entry index being written
//   frat_wr_tag    tag written into that FRAT entry
//   fl_clear       empty the free list (CLEAR)
//   fl_enq         return fl_enq_tag to the free list (SCAN)
//   fl_enq_tag     tag being returned
//   busy_clear_all clear every busy bit (CLEAR)
//   rename_halt    stall rename; also asserted in the flush cycle itself
//   rrat_hold      block retirement / RRAT updates while recovering
//   recovery_done  one-cycle completion pulse (DONE)
module rename_recovery_ctrl #(
  parameter int NUM_ARCH = 32,
  parameter int NUM_PHYS = 64,
  parameter int TAG_W    = 6,
  parameter int ARCH_W   = $clog2(NUM_ARCH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              flush_req,
  input  logic [TAG_W-1:0]  rrat_map [NUM_ARCH],
  output logic              frat_wr_en,
  output logic [ARCH_W-1:0] frat_wr_arch,
  output logic [TAG_W-1:0]  frat_wr_tag,
  output logic              fl_clear,
  output logic              fl_enq,
  output logic [TAG_W-1:0]  fl_enq_tag,
  output logic              busy_clear_all,
  output logic              rename_halt,
  output logic              rrat_hold,
  output logic              recovery_done
);

  localparam int IDX_W = TAG_W + 1;
  localparam logic [IDX_W-1:0] LAST_ARCH = IDX_W'(NUM_ARCH - 1);
  localparam logic [IDX_W-1:0] LAST_PHYS = IDX_W'(NUM_PHYS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    COPY,
    SCAN,
    DONE
  } state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic             tag_in_rrat;

  // State register
  always_ff @(negedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      idx       <= '0;
      rrat_hold <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      rrat_hold <= (state_next != IDLE);
    end
  end

  // Does the current scan tag appear anywhere in the committed map?
  // Duplicate map entries still produce a single hit, so a tag is
  // never enqueued twice.
  always_comb begin
    tag_in_rrat = 1'b0;
    for (int unsigned i = 0; i < NUM_ARCH; i++) begin
      if (rrat_map[i] == idx[TAG_W-1:0]) tag_in_rrat = 1'b1;
    end
  end

  // Next-state / counter
  always_comb begin
    state_next = state;
    idx_next   = idx;
    unique case (state)
      IDLE: ;
      CLEAR: begin
        state_next = COPY;
        idx_next   = '0;
      end
      COPY: begin
        if (idx == LAST_ARCH) begin
          state_next = SCAN;
          idx_next   = '0;
        end else begin
          idx_next = idx + IDX_W'(1);
        end
      end
      SCAN: begin
        if (idx == LAST_PHYS) begin
          state_next = DONE;
          idx_next   = '0;
        end else begin
          idx_next = idx + IDX_W'(1);
        end
      end
      DONE: state_next = IDLE;
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
    // A flush from any state restarts at CLEAR so no partial walk survives.
    if (flush_req) begin
      state_next = CLEAR;
      idx_next   = '0;
    end
  end

  // Moore datapath outputs
  always_comb begin
    frat_wr_en     = 1'b0;
    frat_wr_arch   = '0;
    frat_wr_tag    = '0;
    fl_clear       = 1'b0;
    fl_enq         = 1'b0;
    fl_enq_tag     = '0;
    busy_clear_all = 1'b0;
    recovery_done  = 1'b0;
    unique case (state)
      CLEAR: begin
        fl_clear       = 1'b1;
        busy_clear_all = 1'b1;
      end
      COPY: begin
        frat_wr_en   = 1'b1;
        frat_wr_arch = idx[ARCH_W-1:0];
        frat_wr_tag  = rrat_map[idx[ARCH_W-1:0]];
      end
      SCAN: begin
        fl_enq     = ~tag_in_rrat;
        fl_enq_tag = idx[TAG_W-1:0];
      end
      DONE: recovery_done = 1'b1;
      default: ;
    endcase
  end

  // Combinational so rename stalls in the flush cycle; forced low in reset
  // because flush_req is not itself reset.
  assign rename_halt = RESET & (flush_req | (state != IDLE));

endmodule

// File: tb/tb_rename_recovery_ctrl.sv
module tb_rename_recovery_ctrl;

  localparam int NUM_ARCH = 32;
  localparam int NUM_PHYS = 64;
  localparam int TAG_W    = 6;

  logic             CLK;
  logic             RESET;
  logic             flush_req;
  logic [TAG_W-1:0] rrat_map [NUM_ARCH];
  logic             frat_wr_en;
  logic [4:0]       frat_wr_arch;
  logic [TAG_W-1:0] frat_wr_tag;
  logic             fl_clear;
  logic             fl_enq;
  logic [TAG_W-1:0] fl_enq_tag;
  logic             busy_clear_all;
  logic             rename_halt;
  logic             rrat_hold;
  logic             recovery_done;

  rename_recovery_ctrl #(
    .NUM_ARCH(NUM_ARCH),
    .NUM_PHYS(NUM_PHYS),
    .TAG_W   (TAG_W)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .flush_req     (flush_req),
    .rrat_map      (rrat_map),
    .frat_wr_en    (frat_wr_en),
    .frat_wr_arch  (frat_wr_arch),
    .frat_wr_tag   (frat_wr_tag),
    .fl_clear      (fl_clear),
    .fl_enq        (fl_enq),
    .fl_enq_tag    (fl_enq_tag),
    .busy_clear_all(busy_clear_all),
    .rename_halt   (rename_halt),
    .rrat_hold     (rrat_hold),
    .recovery_done (recovery_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic             wr_en;
    logic [4:0]       arch;
    logic [TAG_W-1:0] wtag;
    logic             clr;
    logic             enq;
    logic [TAG_W-1:0] etag;
    logic             busy;
    logic             done;
    logic             hold;
  } rec_t;

  rec_t             sbq [$];
  logic [TAG_W-1:0] enq_seen [$];
  int               done_seen;
  int               total;
  int               bad;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Expected per-cycle outputs for one full recovery, starting the cycle
  // after the flush is captured.
  task automatic push_recovery();
    rec_t r;
    logic hit;
    r = '0; r.clr = 1'b1; r.busy = 1'b1; r.hold = 1'b1;
    sbq.push_back(r);
    for (int i = 0; i < NUM_ARCH; i++) begin
      r = '0; r.hold = 1'b1; r.wr_en = 1'b1;
      r.arch = 5'(i); r.wtag = rrat_map[i];
      sbq.push_back(r);
    end
    for (int t = 0; t < NUM_PHYS; t++) begin
      hit = 1'b0;
      for (int j = 0; j < NUM_ARCH; j++) if (int'(rrat_map[j]) == t) hit = 1'b1;
      r = '0; r.hold = 1'b1; r.enq = ~hit; r.etag = TAG_W'(t);
      sbq.push_back(r);
    end
    r = '0; r.done = 1'b1; r.hold = 1'b1;
    sbq.push_back(r);
  endtask

  function automatic rec_t observe();
    rec_t o;
    o = {frat_wr_en, frat_wr_arch, frat_wr_tag, fl_clear, fl_enq, fl_enq_tag,
         busy_clear_all, recovery_done, rrat_hold};
    return o;
  endfunction

  // Drive flush for the coming falling edge, then check the outputs of the
  // current cycle against the scoreboard.
  task automatic cycle(input logic f);
    rec_t e, o;
    @(posedge CLK);
    flush_req = f;
    #1;
    e = (sbq.size() > 0) ? sbq.pop_front() : rec_t'('0);
    o = observe();
    chk("outputs", 32'(o), 32'(e));
    chk("rename_halt", 32'(rename_halt), 32'(f | e.hold));
    if (o.enq) enq_seen.push_back(o.etag);
    if (o.done) done_seen++;
    if (f) begin
      sbq.delete();
      push_recovery();
    end
  endtask

  task automatic run_recovery();
    enq_seen.delete();
    done_seen = 0;
    cycle(1'b1);
    for (int i = 0; i < 100; i++) cycle(1'b0);
    chk("done_count", done_seen, 1);
  endtask

  task automatic check_enq(input int first, input int step);
    chk("enq_count", enq_seen.size(), 32);
    for (int i = 0; i < enq_seen.size() && i < 32; i++)
      chk("enq_tag", 32'(enq_seen[i]), 32'(first + step * i));
  endtask

  initial begin
    total = 0; bad = 0; done_seen = 0;
    RESET = 1'b0;
    flush_req = 1'b0;
    for (int i = 0; i < NUM_ARCH; i++) rrat_map[i] = TAG_W'(i);

    // Reset state
    #3;
    chk("reset_outputs", 32'(observe()), 32'(0));
    chk("reset_halt", 32'(rename_halt), 32'(0));
    #4 RESET = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0);

    // Identity map: free list gets 32..63
    run_recovery();
    check_enq(32, 1);

    // Reversed map: free list gets 0..31
    for (int i = 0; i < NUM_ARCH; i++) rrat_map[i] = TAG_W'(63 - i);
    run_recovery();
    check_enq(0, 1);

    // Sparse even map: free list gets odd tags
    for (int i = 0; i < NUM_ARCH; i++) rrat_map[i] = TAG_W'(2 * i);
    run_recovery();
    check_enq(1, 2);

    // Restart 50 cycles into recovery
    for (int i = 0; i < NUM_ARCH; i++) rrat_map[i] = TAG_W'(i);
    done_seen = 0;
    cycle(1'b1);
    for (int i = 0; i < 50; i++) cycle(1'b0);
    enq_seen.delete();
    cycle(1'b1);
    for (int i = 0; i < 100; i++) cycle(1'b0);
    chk("restart_done_count", done_seen, 1);
    check_enq(32, 1);

    // Async reset during COPY at idx 10
    done_seen = 0;
    cycle(1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b0);
    chk("pre_reset_arch", 32'(frat_wr_arch), 32'(10));
    #1 RESET = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(observe()), 32'(0));
    chk("async_reset_halt", 32'(rename_halt), 32'(0));
    sbq.delete();
    for (int i = 0; i < 2; i++) cycle(1'b0);
    #1 RESET = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b0);
    chk("reset_no_done", done_seen, 0);
    run_recovery();
    check_enq(32, 1);

    // Long idle: nothing moves
    done_seen = 0;
    for (int i = 0; i < 200; i++) cycle(1'b0);
    chk("idle_no_done", done_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
